// File: rtl/inst_axi_bridge_pkg.sv
// Shared definitions for the instruction-fetch AXI read bridge:
// FSM state encoding and the fixed AXI read-address channel field values.
package inst_axi_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } bridge_state_t;

    // Every fetch is a single-beat read with ID 0.
    localparam logic [3:0] AXI_ARID       = 4'd0;
    localparam logic [7:0] AXI_ARLEN      = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_ARLOCK     = 2'b00;
    localparam logic [3:0] AXI_ARCACHE    = 4'd0;
    localparam logic [2:0] AXI_ARPROT     = 3'd0;

    // Widen the 2-bit SRAM-style size into the 3-bit AXI arsize field.
    function automatic logic [2:0] to_arsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/inst_axi_bridge.sv
// Instruction SRAM-like to AXI read bridge. One outstanding single-beat
// read; IDLE -> AR -> R -> IDLE. Optional fetch-cancel support is enabled
// with the INST_BRIDGE_CANCEL_EN macro: a cancelled fetch still finishes
// its AXI handshakes but its data is dropped instead of returned.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_en,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        fetch_cancel,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    bridge_state_t state;
    logic [31:0]   addr_q;
    logic [1:0]    size_q;
    logic [31:0]   rdata_q;
    logic          drop_now;

    // Response metadata is irrelevant for single-beat, single-ID reads.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, rlast};

`ifdef INST_BRIDGE_CANCEL_EN
    logic drop;
    // A cancel arriving together with the R beat drops that beat too.
    assign drop_now = drop | fetch_cancel;
`else
    logic unused_cancel;
    assign unused_cancel = fetch_cancel;
    assign drop_now = 1'b0;
`endif

    // Handshake outputs; all forced low while reset is asserted.
    assign inst_sram_addr_ok = resetn & (state == ST_IDLE) & inst_sram_en;
    assign arvalid           = resetn & (state == ST_AR);
    assign rready            = resetn & (state == ST_R);
    assign inst_sram_data_ok = rready & rvalid & ~drop_now;

    // Returned word passes straight through on data_ok, otherwise holds.
    assign inst_sram_rdata = inst_sram_data_ok ? rdata : rdata_q;

    // Constant / latched AR channel fields.
    assign arid    = AXI_ARID;
    assign araddr  = addr_q;
    assign arlen   = AXI_ARLEN;
    assign arsize  = to_arsize(size_q);
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_ARLOCK;
    assign arcache = AXI_ARCACHE;
    assign arprot  = AXI_ARPROT;

    // Bridge FSM: request latch, AR/R sequencing, drop flag and data hold.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            rdata_q <= 32'd0;
`ifdef INST_BRIDGE_CANCEL_EN
            drop    <= 1'b0;
`endif
        end else begin
            if (inst_sram_data_ok) begin
                rdata_q <= rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (inst_sram_en) begin
                        addr_q <= inst_sram_addr;
                        size_q <= inst_sram_size;
                        state  <= ST_AR;
                    end
                end
                ST_AR: begin
`ifdef INST_BRIDGE_CANCEL_EN
                    if (fetch_cancel) begin
                        drop <= 1'b1;
                    end
`endif
                    if (arready) begin
                        state <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        state <= ST_IDLE;
`ifdef INST_BRIDGE_CANCEL_EN
                        drop  <= 1'b0;
`endif
                    end else begin
`ifdef INST_BRIDGE_CANCEL_EN
                        if (fetch_cancel) begin
                            drop <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
